// File: rtl/div_unit_pkg.sv
// ============================================================================
// Module   : div_unit_pkg
// Brief    : Shared CPU definitions for the iterative divider (states, sizes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_ITER  = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITER);

    // Magnitude of a 32-bit value, treating it as signed only when is_signed=1.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Brief    : Multi-cycle restoring radix-2 DIV/DIVU unit for the E stage.
//            Define DIV_FAST_ZERO_EN to short-cut a zero divisor to DONE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        startE,
    input  logic        signedE,
    input  logic [31:0] opaE,
    input  logic [31:0] opbE,
    input  logic        flush,
    input  logic        holdE,
    output logic        div_stallE,
    output logic        readyE,
    output logic [63:0] resultE
);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]          rem_q, rem_d;
    logic [31:0]          quo_q, quo_d;
    logic [31:0]          dvsr_q, dvsr_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [63:0]          result_q, result_d;

    logic                 w_sign_a;
    logic                 w_sign_b;
    logic [32:0]          w_shift;
    logic                 w_ge;
    logic [31:0]          w_rem_step;
    logic [31:0]          w_quo_step;
    logic [31:0]          w_rem_fix;
    logic [31:0]          w_quo_fix;
`ifdef DIV_FAST_ZERO_EN
    logic [31:0]          w_zero_quo;
`endif

    assign w_sign_a = signedE & opaE[31];
    assign w_sign_b = signedE & opbE[31];

    // One restoring step: the 33-bit shifted remainder never exceeds 2*divisor,
    // so the difference always fits back into 32 bits.
    assign w_shift    = {rem_q, quo_q[31]};
    assign w_ge       = (w_shift >= {1'b0, dvsr_q});
    assign w_rem_step = w_ge ? (w_shift[31:0] - dvsr_q) : w_shift[31:0];
    assign w_quo_step = {quo_q[30:0], w_ge};

    assign w_rem_fix  = neg_rem_q ? (~w_rem_step + 32'd1) : w_rem_step;
    assign w_quo_fix  = neg_quo_q ? (~w_quo_step + 32'd1) : w_quo_step;

`ifdef DIV_FAST_ZERO_EN
    assign w_zero_quo = w_sign_a ? 32'h0000_0001 : 32'hFFFF_FFFF;
`endif

    assign div_stallE = startE & ~flush & (state_q != DONE);
    assign readyE     = (state_q == DONE);
    assign resultE    = result_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startE) begin
                        rem_d     = 32'd0;
                        quo_d     = abs32(opaE, signedE);
                        dvsr_d    = abs32(opbE, signedE);
                        neg_quo_d = w_sign_a ^ w_sign_b;
                        neg_rem_d = w_sign_a;
                        cnt_d     = '0;
                        state_d   = RUN;
`ifdef DIV_FAST_ZERO_EN
                        if (opbE == 32'd0) begin
                            state_d  = DONE;
                            result_d = {opaE, w_zero_quo};
                        end
`endif
                    end
                end
                RUN: begin
                    rem_d = w_rem_step;
                    quo_d = w_quo_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == DIV_CNT_W'(DIV_ITER - 1)) begin
                        state_d  = DONE;
                        result_d = {w_rem_fix, w_quo_fix};
                    end
                end
                DONE: begin
                    if (!holdE) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvsr_q    <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port startE  input  1  DIV/DIVU is in the E stage and requests the divider.
REQ-004 SHALL have port signedE  input  1  1 = DIV (signed), 0 = DIVU.
REQ-005 SHALL have port opaE  input  32  dividend (forwarded rs).
REQ-006 SHALL have port opbE  input  32  divisor (forwarded rt).
REQ-007 SHALL have port flush  input  1  exception flush; cancels any operation.
REQ-008 SHALL have port holdE  input  1  E stage frozen by a non-divider stall (memory stall).
REQ-009 SHALL have port div_stallE  output  1  stall request to the hazard unit.
REQ-010 SHALL have port readyE  output  1  resultE is valid this cycle.
REQ-011 SHALL have port resultE  output  64  {remainder (HI), quotient (LO)}.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE.
REQ-013 In IDLE with startE=1 and flush=0: latch operand magnitudes, signs and signedE; go to RUN with iteration count 0.
REQ-014 In RUN: perform one restoring radix-2 step per cycle (shift remainder/quotient left 1, trial-subtract divisor, set the quotient bit if non-negative); after step 31, go to DONE.
REQ-015 In DONE: readyE=1 and resultE held stable; stay while holdE=1; return to IDLE when holdE=0.
REQ-016 div_stallE SHALL equal startE & ~flush & (state != DONE), combinationally; the stall is raised in the same cycle startE first appears.
REQ-017 Latency: startE in cycle 0 gives div_stallE=1 in cycles 0-32 and readyE=1, div_stallE=0 in cycle 33.
REQ-018 Signed fixup: quotient negated when sign(a)^sign(b); remainder negated when sign(a); two's-complement, 32-bit wrap.
REQ-019 0x80000000 / 0xFFFFFFFF (signed) SHALL give quotient 0x80000000, remainder 0.
REQ-020 Divisor 0, unsigned: quotient 0xFFFFFFFF, remainder = dividend.
REQ-021 Divisor 0, signed: remainder = dividend; quotient = 0x00000001 if dividend<0, else 0xFFFFFFFF.
REQ-022 flush=1 in any state SHALL force IDLE at the next edge and discard the partial result; flush has priority over startE and holdE.
REQ-023 Operand changes during RUN SHALL be ignored; only latched values are used.
REQ-024 readyE SHALL be 0 in IDLE and RUN; resultE is don't-care when readyE=0 but SHALL hold its last value rather than glitch.

Reset
REQ-025 resetn=0 SHALL asynchronously force IDLE, iteration count 0, readyE=0 and resultE=0; div_stallE follows REQ-016 (0 unless startE).
REQ-026 Reset mid-RUN SHALL abandon the operation; the first edge after release behaves as IDLE.

Configuration
REQ-027 With DIV_FAST_ZERO_EN defined, startE with opbE=0 in IDLE SHALL go directly to DONE (stall in cycle 0 only, readyE in cycle 1) with the REQ-020/021 results.
REQ-028 Without DIV_FAST_ZERO_EN, divisor 0 SHALL take the full 33-cycle path and produce identical results.

Structure
REQ-029 The state enumeration, DIV_ITER=32 and the iteration-counter width SHALL live in the shared CPU definitions package.
REQ-030 Single module, no sub-module; sign/abs pre- and post-fixup SHALL be combinational logic inside div_unit.

Verification
REQ-031 DIVU 100/7 → stall cycles 0-32, readyE cycle 33, resultE={0x00000002,0x0000000E}.
REQ-032 DIV -7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 0x80000000/-1 → {0x00000000,0x80000000}.
REQ-033 Divisor 0: DIVU 5/0 → {0x00000005,0xFFFFFFFF}; DIV -5/0 → {0xFFFFFFFB,0x00000001}; readyE in cycle 1 with DIV_FAST_ZERO_EN, cycle 33 without.
REQ-034 flush pulsed at RUN step 10 → IDLE next cycle, div_stallE=0 while flush=1, readyE never asserted; a new startE then completes normally.
REQ-035 holdE=1 for 5 cycles across DONE → readyE and resultE stable for all 5; return to IDLE afterwards; no restart while startE stays high during hold.
REQ-036 resetn low at RUN step 20 → outputs return to reset values immediately; next DIVU 9/3 → {0,3} at cycle 33.
